rs_syndrome_ctrl: RTL and testbench



---
 rtl/rs_gf_pkg.sv | 40 ++++
 rtl/rs_syndrome_ctrl_if.sv | 28 ++
 rtl/gfadder.sv | 12 +
 rtl/lcpmult.sv | 12 +
 rtl/rs_synd_bank.sv | 34 +++
 rtl/rs_syndrome_ctrl.sv | 134 +++++++++++++
 tb/tb_rs_syndrome_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^5) constants, helpers and sequencer state encoding shared by the syndrome block.
package rs_gf_pkg;

  localparam int unsigned GF_W = 5;
  localparam int unsigned GF_N = 31;

  // x^5 + x^2 + 1
  localparam logic [GF_W:0] PRIM_POLY = 6'b100101;

  // alpha^k, bit i = coefficient of x^i
  localparam logic [GF_W-1:0] ALPHA_POW [0:GF_N-1] = '{
    5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
    5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
    5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
    5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18
  };

  typedef logic [GF_W-1:0] gf_elem_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } synd_state_e;

  // Shift-and-add multiply with on-the-fly reduction by PRIM_POLY
  function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
    gf_elem_t acc;
    gf_elem_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(GF_W); i++) begin
      if (b[i]) acc = acc ^ sh;
      if (sh[GF_W-1]) sh = {sh[GF_W-2:0], 1'b0} ^ PRIM_POLY[GF_W-1:0];
      else            sh = {sh[GF_W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_syndrome_ctrl_if.sv
// Symbol-in / syndrome-out handshake bundle for rs_syndrome_ctrl.
interface rs_syndrome_ctrl_if #(
  parameter int unsigned T = 2
);
  import rs_gf_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  gf_elem_t                in_sym;
  logic                    synd_valid;
  logic                    synd_ack;
  logic [2*T*GF_W-1:0]     synd_out;
  logic                    zero_synd;
  logic                    busy;

  // Producer/consumer side of the block
  modport master (
    output in_valid, in_sym, synd_ack,
    input  in_ready, synd_valid, synd_out, zero_synd, busy
  );

  // The syndrome sequencer itself
  modport slave (
    input  in_valid, in_sym, synd_ack,
    output in_ready, synd_valid, synd_out, zero_synd, busy
  );

endinterface

// File: rtl/gfadder.sv
// Combinational GF(2^5) adder (bitwise XOR).
module gfadder
  import rs_gf_pkg::*;
(
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t sum_c
);

  assign sum_c = a ^ b;

endmodule

// File: rtl/lcpmult.sv
// Combinational GF(2^5) multiplier shared by all syndrome lanes.
module lcpmult
  import rs_gf_pkg::*;
(
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t prod_c
);

  assign prod_c = gf_mul(a, b);

endmodule

// File: rtl/rs_synd_bank.sv
// 2T x 5-bit syndrome register file: single selected write, bulk clear, flat read.
module rs_synd_bank
  import rs_gf_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               we,
  input  logic [SEL_W-1:0]   sel,
  input  gf_elem_t           wdata,
  output logic [N*GF_W-1:0]  rd_flat
);

  gf_elem_t regs [N];

  // Storage: clear wins over write; only the selected lane is written
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      for (int k = 0; k < int'(N); k++) regs[k] <= '0;
    end else if (we) begin
      regs[sel] <= wdata;
    end
  end

  // Flatten lanes, S1 in the low bits
  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < int'(N); k++) rd_flat[k*GF_W +: GF_W] = regs[k];
  end

endmodule

// File: rtl/rs_syndrome_ctrl.sv
// Horner-rule syndrome sequencer: one shared multiplier/adder walks all 2T lanes per symbol.
module rs_syndrome_ctrl
  import rs_gf_pkg::*;
#(
  parameter int unsigned T    = 2,
  parameter int unsigned NSYM = 31
)(
  input  logic               clock,
  input  logic               reset,
  rs_syndrome_ctrl_if.slave  bus
);

  localparam int unsigned NS    = 2 * T;
  localparam int unsigned J_W   = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CNT_W = $clog2(NSYM);
  localparam logic [J_W-1:0]   J_LAST   = J_W'(NS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);

  synd_state_e           state, state_next;
  gf_elem_t              sym_reg;
  logic [J_W-1:0]        j, j_d;
  logic [CNT_W-1:0]      sym_cnt, sym_cnt_d;
  logic                  synd_valid_q, zero_synd_q, busy_q;
  logic [NS*GF_W-1:0]    synd_flat;

  logic                  in_ready_c;
  logic                  accept_c, bank_we_c, bank_clr_c, last_j_c, enter_done_c;
  logic                  zero_next_c;
  gf_elem_t              synd_sel_c, alpha_sel_c, mult_c, add_c;

  assign in_ready_c = (state == ACCEPT) && !reset;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ACCEPT;
    else       state <= state_next;
  end

  // Next-state: one accept cycle, 2T update cycles, then wait for ack after the last symbol
  always_comb begin
    state_next = state;
    unique case (state)
      ACCEPT: if (bus.in_valid) state_next = UPDATE;
      UPDATE: if (j == J_LAST) state_next = (sym_cnt == CNT_LAST) ? DONE : ACCEPT;
      DONE:   if (bus.synd_ack) state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  // Control decode and counter next values
  always_comb begin
    accept_c     = in_ready_c && bus.in_valid;
    bank_we_c    = (state == UPDATE);
    last_j_c     = (state == UPDATE) && (j == J_LAST);
    enter_done_c = last_j_c && (sym_cnt == CNT_LAST);
    bank_clr_c   = (state == DONE) && bus.synd_ack;

    j_d = j;
    if (accept_c)       j_d = '0;
    else if (last_j_c)  j_d = '0;
    else if (bank_we_c) j_d = J_W'(j + 1'b1);

    sym_cnt_d = sym_cnt;
    if (last_j_c) sym_cnt_d = (sym_cnt == CNT_LAST) ? '0 : CNT_W'(sym_cnt + 1'b1);
  end

  // Operand select for the shared datapath and the look-ahead zero test for DONE entry
  always_comb begin
    gf_elem_t acc;
    synd_sel_c  = synd_flat[int'(j)*GF_W +: GF_W];
    alpha_sel_c = ALPHA_POW[int'(j) + 1];
    acc = add_c;
    for (int k = 0; k < int'(NS); k++) begin
      if (k != int'(j)) acc = acc | synd_flat[k*GF_W +: GF_W];
    end
    zero_next_c = (acc == '0);
  end

  // Sequencer registers and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sym_reg      <= '0;
      j            <= '0;
      sym_cnt      <= '0;
      synd_valid_q <= 1'b0;
      zero_synd_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (accept_c) sym_reg <= bus.in_sym;
      j       <= j_d;
      sym_cnt <= sym_cnt_d;
      if (enter_done_c) begin
        synd_valid_q <= 1'b1;
        zero_synd_q  <= zero_next_c;
      end else if (bank_clr_c) begin
        synd_valid_q <= 1'b0;
        zero_synd_q  <= 1'b0;
      end
      busy_q <= (state_next != ACCEPT) || (sym_cnt_d != '0);
    end
  end

  lcpmult u_mult (
    .a      (synd_sel_c),
    .b      (alpha_sel_c),
    .prod_c (mult_c)
  );

  gfadder u_add (
    .a     (mult_c),
    .b     (sym_reg),
    .sum_c (add_c)
  );

  rs_synd_bank #(
    .N     (NS),
    .SEL_W (J_W)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .clr     (bank_clr_c),
    .we      (bank_we_c),
    .sel     (j),
    .wdata   (add_c),
    .rd_flat (synd_flat)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.synd_valid = synd_valid_q;
  assign bus.synd_out   = synd_flat;
  assign bus.zero_synd  = zero_synd_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Self-checking bench for rs_syndrome_ctrl against a direct-evaluation syndrome model.
module tb_rs_syndrome_ctrl;

  localparam int unsigned T    = 2;
  localparam int unsigned NSYM = 31;
  localparam int unsigned SW   = 10 * T;
  localparam int          LAT  = 155;

  typedef logic [4:0] cw_t [NSYM];

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rs_syndrome_ctrl_if #(.T(T)) bus();

  rs_syndrome_ctrl #(.T(T), .NSYM(NSYM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Polynomial product then long division by x^5+x^2+1
  function automatic logic [4:0] ref_mul(input logic [4:0] a, input logic [4:0] b);
    logic [8:0] prod;
    prod = '0;
    for (int i = 0; i < 5; i++) if (b[i]) prod = prod ^ (9'(a) << i);
    for (int k = 8; k >= 5; k--) if (prod[k]) prod = prod ^ (9'(6'b100101) << (k - 5));
    return prod[4:0];
  endfunction

  function automatic logic [4:0] ref_pow(input int e);
    logic [4:0] p;
    p = 5'd1;
    for (int i = 0; i < e % 31; i++) p = ref_mul(p, 5'd2);
    return p;
  endfunction

  // S_j = sum_i r_i * alpha^(i*j), S1 in the low bits
  function automatic logic [SW-1:0] ref_synd(input cw_t r);
    logic [SW-1:0] out;
    logic [4:0]    s;
    out = '0;
    for (int jj = 1; jj <= int'(2*T); jj++) begin
      s = '0;
      for (int i = 0; i < int'(NSYM); i++) s = s ^ ref_mul(r[i], ref_pow(i * jj));
      out[(jj-1)*5 +: 5] = s;
    end
    return out;
  endfunction

  function automatic cw_t cw_zero();
    cw_t r;
    for (int i = 0; i < int'(NSYM); i++) r[i] = '0;
    return r;
  endfunction

  // Stream r30..r0 in; returns observations once synd_valid is seen
  task automatic feed_codeword(input cw_t r, input bit rnd, output bit done, output int lat,
                               output int extra, output logic [SW-1:0] so, output logic zs);
    int idx;
    int first;
    int budget;
    logic v;
    idx = int'(NSYM) - 1;
    first = -1;
    budget = 0;
    done = 1'b0;
    lat = -1;
    extra = 0;
    while (idx >= 0 && budget < 4000) begin
      @(negedge clock);
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_sym   = bus.in_ready ? r[idx] : 5'($urandom);
      if (rnd) bus.synd_ack = 1'($urandom);
      if (v && bus.in_ready) begin
        if (first < 0) first = cyc;
        idx--;
      end
      @(posedge clock);
      budget++;
    end
    budget = 0;
    while (budget < 400) begin
      @(negedge clock);
      bus.synd_ack = 1'b0;
      if (bus.synd_valid) begin
        done = 1'b1;
        lat = cyc - first;
        break;
      end
      bus.in_valid = 1'b1;
      bus.in_sym   = 5'($urandom);
      if (bus.in_ready) extra++;
      budget++;
    end
    bus.in_valid = 1'b0;
    so = bus.synd_out;
    zs = bus.zero_synd;
  endtask

  task automatic do_ack();
    @(negedge clock);
    bus.synd_ack = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sym   = 5'($urandom);
    @(negedge clock);
    bus.synd_ack = 1'b0;
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.synd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_synd_valid got=%b exp=0", bus.synd_valid); end
    n_checks++;
    if (bus.synd_out !== '0) begin n_fail++; $display("FAIL reset_synd_out got=%h exp=0", bus.synd_out); end
    n_checks++;
    if (bus.zero_synd !== 1'b0) begin n_fail++; $display("FAIL reset_zero_synd got=%b exp=0", bus.zero_synd); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_zero_codeword();
    bit done; int lat, extra; logic [SW-1:0] so; logic zs;
    feed_codeword(cw_zero(), 1'b0, done, lat, extra, so, zs);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_cw_timeout got=%b exp=1", done); end
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL zero_cw_latency got=%0d exp=%0d", lat, LAT); end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL zero_cw_extra_accept got=%0d exp=0", extra); end
    n_checks++;
    if (so !== '0) begin n_fail++; $display("FAIL zero_cw_synd got=%h exp=0", so); end
    n_checks++;
    if (zs !== 1'b1) begin n_fail++; $display("FAIL zero_cw_zero_synd got=%b exp=1", zs); end
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_cw_busy_done got=%b exp=1", bus.busy); end
    do_ack();
    n_checks++;
    if (bus.synd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_cw_ack_valid got=%b exp=0", bus.synd_valid); end
  endtask

  task automatic test_single_error(input int pos, input logic [4:0] val,
                                   input logic [SW-1:0] exp, input bit rnd);
    bit done; int lat, extra; logic [SW-1:0] so; logic zs; cw_t r;
    r = cw_zero();
    r[pos] = val;
    feed_codeword(r, rnd, done, lat, extra, so, zs);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL single_r%0d_timeout got=%b exp=1", pos, done); end
    if (!rnd) begin
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL single_r%0d_latency got=%0d exp=%0d", pos, lat, LAT); end
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL single_r%0d_extra_accept got=%0d exp=0", pos, extra); end
    n_checks++;
    if (so !== exp) begin n_fail++; $display("FAIL single_r%0d_synd rnd=%0d got=%h exp=%h", pos, rnd, so, exp); end
    n_checks++;
    if (zs !== 1'b0) begin n_fail++; $display("FAIL single_r%0d_zero_synd got=%b exp=0", pos, zs); end
    do_ack();
  endtask

  task automatic test_random_valid();
    test_single_error(0, 5'd7, {5'd7, 5'd7, 5'd7, 5'd7}, 1'b1);
    test_single_error(1, 5'd1, {5'd16, 5'd8, 5'd4, 5'd2}, 1'b1);
  endtask

  task automatic test_ack_hold();
    bit done; int lat, extra; logic [SW-1:0] so; logic zs; cw_t r;
    logic [SW-1:0] exp2;
    exp2 = {5'd7, 5'd7, 5'd7, 5'd7};
    r = cw_zero();
    r[0] = 5'd7;
    feed_codeword(r, 1'b0, done, lat, extra, so, zs);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL hold_timeout got=%b exp=1", done); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      bus.in_valid = 1'($urandom);
      n_checks++;
      if (bus.synd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, bus.synd_valid); end
      n_checks++;
      if (bus.synd_out !== exp2) begin n_fail++; $display("FAIL hold_synd c=%0d got=%h exp=%h", c, bus.synd_out, exp2); end
      n_checks++;
      if (bus.zero_synd !== 1'b0) begin n_fail++; $display("FAIL hold_zero c=%0d got=%b exp=0", c, bus.zero_synd); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
    end
    do_ack();
    n_checks++;
    if (bus.synd_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ack_valid got=%b exp=0", bus.synd_valid); end
    n_checks++;
    if (bus.synd_out !== '0) begin n_fail++; $display("FAIL hold_ack_synd got=%h exp=0", bus.synd_out); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ack_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_ack_busy got=%b exp=0", bus.busy); end
    test_single_error(1, 5'd1, {5'd16, 5'd8, 5'd4, 5'd2}, 1'b0);
  endtask

  task automatic test_mid_reset();
    bit done; int lat, extra; logic [SW-1:0] so; logic zs; cw_t r;
    int got; int budget;
    r = cw_zero();
    r[0] = 5'd7;
    got = 0;
    budget = 0;
    while (got < 10 && budget < 200) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_sym   = r[int'(NSYM) - 1 - got];
      if (bus.in_ready) got++;
      @(posedge clock);
      budget++;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready_in_reset got=%b exp=0", bus.in_ready); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.synd_valid !== 1'b0 || bus.synd_out !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got_valid=%b got_synd=%h exp=0", bus.synd_valid, bus.synd_out);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    r = cw_zero();
    r[1] = 5'd1;
    feed_codeword(r, 1'b0, done, lat, extra, so, zs);
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d exp=%0d", lat, LAT); end
    n_checks++;
    if (so !== {5'd16, 5'd8, 5'd4, 5'd2}) begin n_fail++; $display("FAIL midrst_fresh_synd got=%h exp=%h", so, {5'd16, 5'd8, 5'd4, 5'd2}); end
    // Reset while syndromes are being held
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.synd_valid !== 1'b0 || bus.synd_out !== '0 || bus.zero_synd !== 1'b0) begin
      n_fail++; $display("FAIL done_rst_outputs got_valid=%b got_synd=%h got_zero=%b exp=0",
                         bus.synd_valid, bus.synd_out, bus.zero_synd);
    end
  endtask

  task automatic test_random_codewords();
    bit done; int lat, extra; logic [SW-1:0] so, exp; logic zs; cw_t r;
    for (int n = 0; n < 5; n++) begin
      r = cw_zero();
      if (n == 4) begin
        for (int i = 0; i < int'(NSYM); i++) r[i] = 5'($urandom);
      end else begin
        for (int e = 0; e < n; e++) r[$urandom_range(0, NSYM-1)] = 5'($urandom_range(1, 31));
      end
      exp = ref_synd(r);
      feed_codeword(r, 1'b1, done, lat, extra, so, zs);
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL rand_cw%0d_timeout got=%b exp=1", n, done); end
      n_checks++;
      if (so !== exp) begin n_fail++; $display("FAIL rand_cw%0d_synd got=%h exp=%h", n, so, exp); end
      n_checks++;
      if (zs !== (exp == '0)) begin n_fail++; $display("FAIL rand_cw%0d_zero got=%b exp=%b", n, zs, (exp == '0)); end
      n_checks++;
      if (extra != 0) begin n_fail++; $display("FAIL rand_cw%0d_extra_accept got=%0d exp=0", n, extra); end
      do_ack();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sym   = '0;
    bus.synd_ack = 1'b0;
    test_reset();
    test_zero_codeword();
    test_single_error(0, 5'd7, {5'd7, 5'd7, 5'd7, 5'd7}, 1'b0);
    test_single_error(1, 5'd1, {5'd16, 5'd8, 5'd4, 5'd2}, 1'b0);
    test_random_valid();
    test_ack_hold();
    test_mid_reset();
    test_random_codewords();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
